// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data and per-cycle
// overflow/underflow flags. Storage is a plain register array, not reset.
module fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read_en,
    input  logic             write_en,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] read_data,
    output logic             full,
    output logic             empty,
    output logic             write_error,
    output logic             read_error
);

    localparam int PTR_DEPTH = $clog2(DEPTH);
    localparam logic [PTR_DEPTH:0]   COUNT_FULL = (PTR_DEPTH+1)'(DEPTH);
    localparam logic [PTR_DEPTH-1:0] PTR_ONE    = PTR_DEPTH'(1);
    localparam logic [PTR_DEPTH:0]   COUNT_ONE  = (PTR_DEPTH+1)'(1);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [PTR_DEPTH-1:0] r_wp;
    logic [PTR_DEPTH-1:0] r_rp;
    logic [PTR_DEPTH:0]   r_count;
    logic [WIDTH-1:0]     r_read_data;
    logic                 r_write_error;
    logic                 r_read_error;

    logic w_rd_ok;
    logic w_wr_ok;

    assign full  = (r_count == COUNT_FULL);
    assign empty = (r_count == '0);

    // A read freeing a slot on the same edge lets a write into a full FIFO.
    assign w_rd_ok = read_en && !empty;
    assign w_wr_ok = write_en && (!full || w_rd_ok);

    assign read_data   = r_read_data;
    assign write_error = r_write_error;
    assign read_error  = r_read_error;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wp] <= write_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp          <= '0;
            r_rp          <= '0;
            r_count       <= '0;
            r_read_data   <= '0;
            r_write_error <= 1'b0;
            r_read_error  <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wp <= r_wp + PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rp        <= r_rp + PTR_ONE;
                r_read_data <= r_mem[r_rp];
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase
            r_write_error <= write_en && !w_wr_ok;
            r_read_error  <= read_en && !w_rd_ok;
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: fill/drain, overflow, underflow, concurrent
// access at empty and full, and asynchronous reset mid-operation.
module tb_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    logic             clk;
    logic             rst;
    logic             read_en;
    logic             write_en;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic             full;
    logic             empty;
    logic             write_error;
    logic             read_error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] words  [DEPTH];
    logic [WIDTH-1:0] words2 [DEPTH];
    logic [WIDTH-1:0] cwords [DEPTH];

    fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .read_en     (read_en),
        .write_en    (write_en),
        .write_data  (write_data),
        .read_data   (read_data),
        .full        (full),
        .empty       (empty),
        .write_error (write_error),
        .read_error  (read_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        read_en    = 1'b0;
        write_en   = 1'b0;
        write_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            words[i]  = WIDTH'($urandom);
            words2[i] = WIDTH'($urandom);
            cwords[i] = WIDTH'($urandom);
        end

        // Reset state, asynchronous (checked before any clock edge)
        #2;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rdata", 32'(read_data), 32'd0);
        check("rst_werr", 32'(write_error), 32'd0);
        check("rst_rerr", 32'(read_error), 32'd0);
        // Writes under reset must be ignored
        write_en = 1'b1; write_data = 16'hDEAD;
        tick();
        write_en = 1'b0;
        check("rst_hold_empty", 32'(empty), 32'd1);
        tick();
        rst = 1'b1;

        // Fill to full
        for (int i = 0; i < DEPTH; i++) begin
            write_en = 1'b1; write_data = words[i];
            tick();
            check("fill_werr", 32'(write_error), 32'd0);
            check("fill_empty", 32'(empty), 32'd0);
            check("fill_full", 32'(full), (i == DEPTH-1) ? 32'd1 : 32'd0);
        end
        write_en = 1'b0;

        // Drain in order
        for (int i = 0; i < DEPTH; i++) begin
            read_en = 1'b1;
            tick();
            check("drain_data", 32'(read_data), 32'(words[i]));
            check("drain_rerr", 32'(read_error), 32'd0);
            check("drain_empty", 32'(empty), (i == DEPTH-1) ? 32'd1 : 32'd0);
        end
        read_en = 1'b0;
        tick();
        check("idle_hold_data", 32'(read_data), 32'(words[DEPTH-1]));

        // Underflow after reset
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            read_en = 1'b1;
            tick();
            check("uflow_empty", 32'(empty), 32'd1);
            check("uflow_rerr", 32'(read_error), 32'd1);
            check("uflow_rdata", 32'(read_data), 32'd0);
        end
        read_en = 1'b0;
        tick();
        check("uflow_rerr_clear", 32'(read_error), 32'd0);

        // Overflow: 21 writes, 16 accepted
        for (int i = 0; i < 21; i++) begin
            write_en = 1'b1;
            write_data = (i < DEPTH) ? words2[i] : 16'hBAD0 + 16'(i);
            tick();
            check("oflow_werr", 32'(write_error), (i >= DEPTH) ? 32'd1 : 32'd0);
            check("oflow_full", 32'(full), (i >= DEPTH-1) ? 32'd1 : 32'd0);
        end
        write_en = 1'b0;
        tick();
        check("oflow_werr_clear", 32'(write_error), 32'd0);
        check("oflow_full_hold", 32'(full), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            read_en = 1'b1;
            tick();
            check("oflow_readback", 32'(read_data), 32'(words2[i]));
        end
        read_en = 1'b0;
        check("oflow_drained", 32'(empty), 32'd1);

        // Concurrent read+write starting from empty
        for (int i = 0; i < DEPTH; i++) begin
            read_en = 1'b1; write_en = 1'b1; write_data = cwords[i];
            tick();
            check("conc_empty", 32'(empty), 32'd0);
            check("conc_full", 32'(full), 32'd0);
            check("conc_werr", 32'(write_error), 32'd0);
            if (i == 0) begin
                check("conc_first_rerr", 32'(read_error), 32'd1);
                check("conc_first_hold", 32'(read_data), 32'(words2[DEPTH-1]));
            end else begin
                check("conc_rerr", 32'(read_error), 32'd0);
                check("conc_data", 32'(read_data), 32'(cwords[i-1]));
            end
        end
        write_en = 1'b0;
        tick();
        read_en = 1'b0;
        check("conc_last", 32'(read_data), 32'(cwords[DEPTH-1]));
        check("conc_last_empty", 32'(empty), 32'd1);

        // Concurrent read+write while full
        for (int i = 0; i < DEPTH; i++) begin
            write_en = 1'b1; write_data = words[i];
            tick();
        end
        read_en = 1'b1; write_data = 16'h5A5A;
        tick();
        read_en = 1'b0; write_en = 1'b0;
        check("full_rw_full", 32'(full), 32'd1);
        check("full_rw_werr", 32'(write_error), 32'd0);
        check("full_rw_data", 32'(read_data), 32'(words[0]));
        for (int i = 1; i <= DEPTH; i++) begin
            read_en = 1'b1;
            tick();
            check("full_rw_order", 32'(read_data), (i < DEPTH) ? 32'(words[i]) : 32'h5A5A);
        end
        read_en = 1'b0;
        check("full_rw_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) begin
            write_en = 1'b1; write_data = words2[i];
            tick();
        end
        write_en = 1'b0; read_en = 1'b1;
        tick();
        read_en = 1'b0;
        check("mid_pre_data", 32'(read_data), 32'(words2[0]));
        rst = 1'b0;
        #1;
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_full", 32'(full), 32'd0);
        check("mid_rst_rdata", 32'(read_data), 32'd0);
        #2;
        rst = 1'b1;
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        check("mid_post_rerr", 32'(read_error), 32'd1);
        check("mid_post_empty", 32'(empty), 32'd1);
        check("mid_post_rdata", 32'(read_data), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter WIDTH, default 16, data bits per entry.
REQ-002 Parameter DEPTH, default 16, number of storage entries; power of two, at least 2.
REQ-003 Derived PTR_DEPTH = clog2(DEPTH), pointer width; occupancy count is PTR_DEPTH+1 bits.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 read_en  input  1  read request, sampled at rising clk.
REQ-008 write_en  input  1  write request, sampled at rising clk.
REQ-009 write_data  input  WIDTH  data written on accepted write.
REQ-010 read_data  output  WIDTH  registered data from last accepted read.
REQ-011 full  output  1  high when count == DEPTH.
REQ-012 empty  output  1  high when count == 0.
REQ-013 write_error  output  1  registered flag, rejected write in previous cycle.
REQ-014 read_error  output  1  registered flag, rejected read in previous cycle.
REQ-015 Port order: clk, rst, read_en, write_en, write_data, read_data, full, empty, write_error, read_error.

Function
REQ-016 Storage: DEPTH x WIDTH register array, write pointer wp, read pointer rp, occupancy count.
REQ-017 full and empty are combinational decodes of count, with no extra latency.
REQ-018 Accepted write: write_en=1 and (full=0, or read accepted in the same cycle). On the edge: mem[wp] <= write_data, wp increments.
REQ-019 Accepted read: read_en=1 and empty=0. On the edge: read_data <= mem[rp], rp increments; one-cycle latency from request edge to data.
REQ-020 Pointers wrap from DEPTH-1 to 0 with no gap; the full storage capacity of DEPTH entries is usable.
REQ-021 count: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-022 Simultaneous read+write while full: both accepted, count stays DEPTH, write_error=0.
REQ-023 Simultaneous read+write while empty: write accepted, read rejected, read_error=1 next cycle, read_data holds.
REQ-024 Simultaneous read+write with 0<count<DEPTH: both accepted, ordering preserved (read returns oldest entry).
REQ-025 Rejected write (write_en=1, full=1, no accepted read): no storage or pointer change; write_error=1 for the following cycle.
REQ-026 Rejected read (read_en=1, empty=1): no state change, read_data holds; read_error=1 for the following cycle.
REQ-027 Error flags are recomputed every cycle and are not sticky; they clear on the first edge without a rejected request.
REQ-028 read_data holds its value when no read is accepted.
REQ-029 Data order is strictly first-in, first-out.

Reset
REQ-030 While rst=0, regardless of clk: wp=0, rp=0, count=0, read_data=0, write_error=0, read_error=0; hence empty=1, full=0.
REQ-031 Storage array contents need not be cleared; stale data is never observable after reset because count=0.
REQ-032 Reset asserted mid-operation discards all contents immediately. Operation resumes on the first rising clk after rst returns high.

Verification
REQ-033 Full write: after reset, write 16 random words on consecutive edges -> full=1 after the 16th edge, empty=0, write_error=0.
REQ-034 Full write then read: after REQ-033, 16 consecutive reads -> read_data matches write order one cycle after each read edge; empty=1 after the 16th; read_error=0.
REQ-035 Read error: read 16 times on an empty FIFO -> empty stays 1, read_error=1 from the cycle after the first read, read_data=0.
REQ-036 Write error: 21 consecutive writes -> full=1 after write 16; write_error=1 for the cycles after writes 17-21, then 0 once write_en drops; first 16 words read back intact.
REQ-037 Concurrent: read_en=1 and write_en=1 from empty for 16 cycles -> first cycle gives read_error=1 and count 1; afterwards count stays 1, each read returns the word written on the previous cycle, never full.
REQ-038 Reset mid-operation: write 5 words, drop rst for 3 ns between edges -> immediately empty=1, count 0, read_data=0; a subsequent read gives read_error=1.
